sys_debug_ctrl: RTL and testbench

//  Synthesizable debug/run-control unit placed between the board I/O and the MIPS core (system).

---
 rtl/sys_debug_ctrl_pkg.sv | 18 +
 rtl/sys_dbg_runctl.sv | 68 ++++++
 rtl/sys_debug_ctrl.sv | 90 +++++++++
 tb/tb_sys_debug_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sys_debug_ctrl_pkg.sv
// Shared encodings for the debug/run-control unit: display modes and run-control states.
package sys_debug_ctrl_pkg;
  localparam logic [1:0] MODE_LIVE   = 2'b00;
  localparam logic [1:0] MODE_FREEZE = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } dbg_state_t;

  // Encoding 11 is unused and folds onto LIVE.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_LIVE : m;
  endfunction
endpackage

// File: rtl/sys_dbg_runctl.sv
// Run control: input edge detects, RUN/HALT/STEP/BRK FSM, breakpoint re-trap guard.
module sys_dbg_runctl
  import sys_debug_ctrl_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  input  logic            snap,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_pc,
  input  logic [PC_W-1:0] cur_pc,
  output logic            cpu_en,
  output logic            halted,
  output logic            bp_hit,
  output logic            snap_edge,
  output logic            brk_entry
);
  localparam dbg_state_t RST_ST = RUN_ON_RESET ? ST_RUN : ST_HALT;

  dbg_state_t state, nxt;
  logic run_q, step_q, snap_q, skip_bp;
  logic run_edge, step_edge, bp_match, leave_brk;

  assign run_edge  = run & ~run_q;
  assign step_edge = step & ~step_q;
  assign snap_edge = snap & ~snap_q;
  assign bp_match  = bp_en && (cur_pc == bp_pc) && !skip_bp;
  assign brk_entry = (state == ST_RUN) && bp_match;
  assign leave_brk = (state == ST_BRK) && (nxt != ST_BRK);

  always_comb begin
    nxt = state;
    case (state)
      ST_RUN:  if (bp_match) nxt = ST_BRK; else if (!run) nxt = ST_HALT;
      ST_STEP: nxt = ST_HALT;
      default: if (run_edge) nxt = ST_RUN; else if (step_edge) nxt = ST_STEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_ST;
      cpu_en  <= RUN_ON_RESET;
      halted  <= !RUN_ON_RESET;
      bp_hit  <= 1'b0;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      snap_q  <= 1'b0;
      skip_bp <= 1'b0;
    end else begin
      state  <= nxt;
      cpu_en <= (nxt == ST_RUN) || (nxt == ST_STEP);
      halted <= (nxt == ST_HALT) || (nxt == ST_BRK);
      run_q  <= run;
      step_q <= step;
      snap_q <= snap;
      if (brk_entry)      bp_hit <= 1'b1;
      else if (leave_brk) bp_hit <= 1'b0;
      // Guard stays up until the core moves off the trapped PC.
      if (leave_brk)               skip_bp <= 1'b1;
      else if (cur_pc != bp_pc)    skip_bp <= 1'b0;
    end
  end
endmodule

// File: rtl/sys_debug_ctrl.sv
// Debug/run-control top: probe shadow registers, scan sequencer and LED display mux.
module sys_debug_ctrl
  import sys_debug_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 32,
  parameter int LED_W        = 27,
  parameter int PC_W         = 8,
  parameter int SCAN_DIV     = 4,
  parameter bit RUN_ON_RESET = 1'b1,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_reset,
  input  logic [1:0]               SYS_mode,
  input  logic [CH_W-1:0]          SYS_output_sel,
  input  logic                     SYS_snap,
  input  logic                     SYS_run,
  input  logic                     SYS_step,
  input  logic                     bp_en,
  input  logic [PC_W-1:0]          bp_pc,
  input  logic [PC_W-1:0]          cur_pc,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  output logic                     cpu_en,
  output logic                     halted,
  output logic                     bp_hit,
  output logic [LED_W-1:0]         SYS_leds,
  output logic [CH_W-1:0]          scan_ch
);
  localparam int DW    = LED_W - CH_W;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_CH-1:0][DATA_W-1:0] probe, shadow;
  logic [1:0]       mode, mode_q;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch;
  logic [DATA_W-1:0] word;
  logic [DW-1:0]    data;
  logic snap_edge, brk_entry, capture;

  assign probe   = probe_bus;
  assign mode    = eff_mode(SYS_mode);
  assign capture = snap_edge | brk_entry | ((mode == MODE_FREEZE) && (mode_q != MODE_FREEZE));
  assign ch      = (mode == MODE_SCAN) ? scan_ch : SYS_output_sel;
  assign word    = (mode == MODE_FREEZE) ? shadow[ch] : probe[ch];

  if (DATA_W >= DW) begin : g_trunc
    logic unused_hi;
    assign data      = word[DW-1:0];
    assign unused_hi = ^word;
  end else begin : g_ext
    assign data = {{(DW-DATA_W){1'b0}}, word};
  end

  sys_dbg_runctl #(.PC_W(PC_W), .RUN_ON_RESET(RUN_ON_RESET)) u_runctl (
    .clk(SYS_clk), .rst_n(SYS_reset),
    .run(SYS_run), .step(SYS_step), .snap(SYS_snap),
    .bp_en(bp_en), .bp_pc(bp_pc), .cur_pc(cur_pc),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
    .snap_edge(snap_edge), .brk_entry(brk_entry)
  );

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      shadow   <= '0;
      mode_q   <= MODE_LIVE;
      cnt      <= '0;
      scan_ch  <= '0;
      SYS_leds <= '0;
    end else begin
      if (capture) shadow <= probe;
      mode_q   <= mode;
      SYS_leds <= {ch, data};
      if (mode == MODE_SCAN) begin
        if (mode_q != MODE_SCAN) begin
          cnt     <= '0;
          scan_ch <= '0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
          cnt     <= '0;
          scan_ch <= scan_ch + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt     <= '0;
        scan_ch <= SYS_output_sel;
      end
    end
  end
endmodule

// File: tb/tb_sys_debug_ctrl.sv
// Directed bench for sys_debug_ctrl: run control, breakpoints, stepping and LED display modes.
module tb_sys_debug_ctrl;
  import sys_debug_ctrl_pkg::*;

  logic         SYS_clk = 1'b0;
  logic         SYS_reset = 1'b1;
  logic [1:0]   SYS_mode;
  logic [2:0]   SYS_output_sel;
  logic         SYS_snap, SYS_run, SYS_step, bp_en;
  logic [7:0]   bp_pc, cur_pc;
  logic [7:0][31:0] pr;
  logic [255:0] probe_bus;
  logic         cpu_en, halted, bp_hit;
  logic [26:0]  SYS_leds;
  logic [2:0]   scan_ch;
  int n_cmp = 0;
  int n_err = 0;

  assign probe_bus = pr;
  always #5 SYS_clk = ~SYS_clk;

  sys_debug_ctrl dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_mode(SYS_mode),
    .SYS_output_sel(SYS_output_sel), .SYS_snap(SYS_snap), .SYS_run(SYS_run),
    .SYS_step(SYS_step), .bp_en(bp_en), .bp_pc(bp_pc), .cur_pc(cur_pc),
    .probe_bus(probe_bus), .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
    .SYS_leds(SYS_leds), .scan_ch(scan_ch)
  );

  task automatic tick();
    @(posedge SYS_clk); #1;
  endtask

  task automatic set_probes();
    for (int k = 0; k < 8; k++) pr[k] = 32'hDEAD0000 + k * 32'h1111;
  endtask

  task automatic test_reset();
    SYS_mode = MODE_LIVE; SYS_output_sel = 3'd0; SYS_snap = 0; SYS_run = 1; SYS_step = 0;
    bp_en = 0; bp_pc = 8'h00; cur_pc = 8'h00; set_probes();
    #2 SYS_reset = 1'b0;
    #1 SYS_reset = 1'b1;
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL reset_cpu_en: got %b want 1", cpu_en); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_err++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit); end
    n_cmp++; if (SYS_leds !== 27'h0) begin n_err++; $display("FAIL reset_leds: got %h want 0", SYS_leds); end
    n_cmp++; if (scan_ch !== 3'd0) begin n_err++; $display("FAIL reset_scan_ch: got %0d want 0", scan_ch); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL run_hold cyc %0d: got %b want 1", i, cpu_en); end
    end
  endtask

  task automatic test_live();
    SYS_output_sel = 3'd3; tick();
    n_cmp++; if (SYS_leds !== {3'd3, 24'hAD3333}) begin n_err++; $display("FAIL live_ch3: got %h want %h", SYS_leds, {3'd3, 24'hAD3333}); end
    SYS_output_sel = 3'd7; tick();
    n_cmp++; if (SYS_leds !== {3'd7, 24'hAD7777}) begin n_err++; $display("FAIL live_ch7: got %h want %h", SYS_leds, {3'd7, 24'hAD7777}); end
  endtask

  task automatic test_breakpoint();
    SYS_mode = MODE_FREEZE; SYS_output_sel = 3'd0; tick(); tick();
    bp_pc = 8'h0C; bp_en = 1;
    for (int i = 0; i < 4; i++) begin
      cur_pc = 8'(i * 4);
      pr[0] = (i == 3) ? 32'h0000C0DE : 32'h0;
      tick();
      if (i < 3) begin
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL bp_pre pc %h: got %b want 1", cur_pc, cpu_en); end
      end else begin
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL bp_cpu_en: got %b want 0", cpu_en); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL bp_halted: got %b want 1", halted); end
        n_cmp++; if (bp_hit !== 1'b1) begin n_err++; $display("FAIL bp_hit: got %b want 1", bp_hit); end
      end
    end
    pr[0] = 32'h11111111; tick(); tick();
    n_cmp++; if (SYS_leds !== {3'd0, 24'h00C0DE}) begin n_err++; $display("FAIL bp_snapshot: got %h want %h", SYS_leds, {3'd0, 24'h00C0DE}); end
  endtask

  task automatic test_resume();
    SYS_run = 0; tick();
    n_cmp++; if (bp_hit !== 1'b1 || halted !== 1'b1) begin n_err++; $display("FAIL brk_hold: got hit %b halted %b want 1 1", bp_hit, halted); end
    SYS_run = 1; tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL resume_cpu_en: got %b want 1", cpu_en); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_err++; $display("FAIL resume_bp_hit: got %b want 0", bp_hit); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", halted); end
    tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL no_retrap: got %b want 1", cpu_en); end
    cur_pc = 8'h10; tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL run_pc10: got %b want 1", cpu_en); end
    cur_pc = 8'h0C; tick();
    n_cmp++; if (cpu_en !== 1'b0 || bp_hit !== 1'b1) begin n_err++; $display("FAIL retrap: got en %b hit %b want 0 1", cpu_en, bp_hit); end
  endtask

  task automatic test_step();
    int pulses;
    bp_en = 0; SYS_run = 0; tick();
    SYS_run = 1; tick();
    SYS_run = 0; tick();
    n_cmp++; if (halted !== 1'b1 || cpu_en !== 1'b0 || bp_hit !== 1'b0) begin n_err++; $display("FAIL halt_state: got h %b en %b hit %b want 1 0 0", halted, cpu_en, bp_hit); end
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      SYS_step = 1; tick();
      n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL step_pulse %0d: got %b want 1", p, cpu_en); end
      pulses += int'(cpu_en);
      SYS_step = 0;
      for (int c = 0; c < 3; c++) begin tick(); pulses += int'(cpu_en); end
    end
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL step_count: got %0d want 3", pulses); end
    SYS_run = 1; SYS_step = 1; tick();
    n_cmp++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL run_step_tie: got en %b h %b want 1 0", cpu_en, halted); end
    SYS_step = 0; tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL run_step_tie_hold: got %b want 1", cpu_en); end
  endtask

  task automatic test_scan();
    logic [2:0]  e;
    logic [26:0] exp_led;
    int prev;
    set_probes(); SYS_output_sel = 3'd5; SYS_mode = MODE_SCAN;
    for (int i = 0; i < 36; i++) begin
      tick();
      e = 3'((i / 4) % 8);
      n_cmp++; if (scan_ch !== e) begin n_err++; $display("FAIL scan_ch cyc %0d: got %0d want %0d", i, scan_ch, e); end
      if (i > 0) begin
        prev = ((i - 1) / 4) % 8;
        exp_led = {3'(prev), pr[prev][23:0]};
        n_cmp++; if (SYS_leds !== exp_led) begin n_err++; $display("FAIL scan_leds cyc %0d: got %h want %h", i, SYS_leds, exp_led); end
      end
    end
  endtask

  task automatic test_freeze();
    pr[2] = 32'h1234; SYS_output_sel = 3'd2; SYS_mode = MODE_FREEZE; tick(); tick();
    n_cmp++; if (SYS_leds !== {3'd2, 24'h001234}) begin n_err++; $display("FAIL freeze_entry: got %h want %h", SYS_leds, {3'd2, 24'h001234}); end
    pr[2] = 32'hBEEF; tick(); tick();
    n_cmp++; if (SYS_leds !== {3'd2, 24'h001234}) begin n_err++; $display("FAIL freeze_hold: got %h want %h", SYS_leds, {3'd2, 24'h001234}); end
    SYS_snap = 1; tick();
    n_cmp++; if (SYS_leds !== {3'd2, 24'h001234}) begin n_err++; $display("FAIL snap_same_cyc: got %h want %h", SYS_leds, {3'd2, 24'h001234}); end
    SYS_snap = 0; tick();
    n_cmp++; if (SYS_leds !== {3'd2, 24'h00BEEF}) begin n_err++; $display("FAIL snap_update: got %h want %h", SYS_leds, {3'd2, 24'h00BEEF}); end
    SYS_mode = 2'b11; pr[2] = 32'h00CAFE00; tick();
    n_cmp++; if (SYS_leds !== {3'd2, 24'hCAFE00}) begin n_err++; $display("FAIL mode11_live: got %h want %h", SYS_leds, {3'd2, 24'hCAFE00}); end
  endtask

  task automatic test_reset_mid();
    SYS_mode = MODE_SCAN;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (scan_ch !== 3'd1) begin n_err++; $display("FAIL pre_reset_scan: got %0d want 1", scan_ch); end
    #2 SYS_reset = 1'b0;
    #1;
    n_cmp++; if (scan_ch !== 3'd0 || SYS_leds !== 27'h0) begin n_err++; $display("FAIL mid_reset: got ch %0d leds %h want 0 0", scan_ch, SYS_leds); end
    n_cmp++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL mid_reset_ctl: got en %b h %b want 1 0", cpu_en, halted); end
    SYS_reset = 1'b1; tick();
    n_cmp++; if (scan_ch !== 3'd0) begin n_err++; $display("FAIL post_reset_scan: got %0d want 0", scan_ch); end
  endtask

  initial begin
    test_reset();
    test_live();
    test_breakpoint();
    test_resume();
    test_step();
    test_scan();
    test_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
